// File: rtl/justtest_regbank.sv
// -----------------------------------------------------------------------------
// justtest_regbank
//
// AXI4-Lite slave register bank with C_NUM_REGS registers, each C_DATA_WIDTH
// bits wide. The write address (AW) and write data (W) channels are accepted
// independently. Each is parked in a holding register. The write commits on
// the edge after both are held. Only one write is in flight at a time. The
// read path has one cycle of latency and runs alongside the write path.
//
// Ports
//   ACLK, ARESETN        clock (rising edge), async active-low reset
//   s_axi_aw*            write address channel (awprot ignored)
//   s_axi_w*             write data channel with byte strobes
//   s_axi_b*             write response channel
//   s_axi_ar*            read address channel (arprot ignored)
//   s_axi_r*             read data channel
//   reg_q                flattened register contents, register k at
//                        [k*C_DATA_WIDTH +: C_DATA_WIDTH]
//   wr_pulse             one-cycle strobe per register on write commit
//
// Build option
//   JUSTTEST_REGBANK_SLVERR_EN  when defined, an access with an index of
//                               C_NUM_REGS or more returns SLVERR (2'b10).
//                               When undefined, it returns OKAY. Either way
//                               the write is dropped, and a read returns 0.
// -----------------------------------------------------------------------------
module justtest_regbank #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_REGS   = 8,
  parameter int C_ADDR_WIDTH = 8
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]            s_axi_awaddr,
  input  logic [2:0]                         s_axi_awprot,
  input  logic                               s_axi_awvalid,
  output logic                               s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]            s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0]          s_axi_wstrb,
  input  logic                               s_axi_wvalid,
  output logic                               s_axi_wready,
  output logic [1:0]                         s_axi_bresp,
  output logic                               s_axi_bvalid,
  input  logic                               s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0]            s_axi_araddr,
  input  logic [2:0]                         s_axi_arprot,
  input  logic                               s_axi_arvalid,
  output logic                               s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]            s_axi_rdata,
  output logic [1:0]                         s_axi_rresp,
  output logic                               s_axi_rvalid,
  input  logic                               s_axi_rready,
  output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_q,
  output logic [C_NUM_REGS-1:0]              wr_pulse
);

  localparam int STRB_W = C_DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = C_ADDR_WIDTH - LSB;
  // One extra bit so that C_NUM_REGS itself fits even when it is a power of two.
  localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W+1)'(C_NUM_REGS);

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef JUSTTEST_REGBANK_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  // State
  logic                    ready_en_q, ready_en_d;
  logic                    aw_held_q,  aw_held_d;
  logic [IDX_W-1:0]        aw_idx_q,   aw_idx_d;
  logic                    w_held_q,   w_held_d;
  logic [C_DATA_WIDTH-1:0] wdata_q,    wdata_d;
  logic [STRB_W-1:0]       wstrb_q,    wstrb_d;
  logic                    bvalid_q,   bvalid_d;
  logic [1:0]              bresp_q,    bresp_d;
  logic [C_NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
  logic                    rvalid_q,   rvalid_d;
  logic [C_DATA_WIDTH-1:0] rdata_q,    rdata_d;
  logic [1:0]              rresp_q,    rresp_d;
  logic [C_DATA_WIDTH-1:0] regs_q [C_NUM_REGS];
  logic [C_DATA_WIDTH-1:0] regs_d [C_NUM_REGS];

  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic [IDX_W-1:0] ar_idx;
  logic             aw_in_range, ar_in_range;

  // Byte-offset bits and prot carry no meaning for this bank.
  logic unused_bits;
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

  // ready_en_q holds every ready low until the first edge after reset is released.
  // Each ready also stays low while its own request is held or a response is pending.
  assign s_axi_awready = ready_en_q & ~aw_held_q & ~bvalid_q;
  assign s_axi_wready  = ready_en_q & ~w_held_q  & ~bvalid_q;
  assign s_axi_arready = ready_en_q & ~rvalid_q;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid  & s_axi_wready;
  assign b_hs   = bvalid_q & s_axi_bready;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign r_hs   = rvalid_q & s_axi_rready;
  assign commit = aw_held_q & w_held_q;

  assign ar_idx      = s_axi_araddr[C_ADDR_WIDTH-1:LSB];
  assign aw_in_range = ({1'b0, aw_idx_q} < NUM_REGS_L);
  assign ar_in_range = ({1'b0, ar_idx}   < NUM_REGS_L);

  // Write path: capture AW and W, then commit the write and raise the B response.
  always_comb begin
    ready_en_d = 1'b1;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi_awaddr[C_ADDR_WIDTH-1:LSB];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata;
      wstrb_d  = s_axi_wstrb;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_in_range ? RESP_OKAY : RESP_OOR;
      // An out-of-range index matches no k, so it updates nothing and pulses nothing.
      for (int k = 0; k < C_NUM_REGS; k++) begin
        if (aw_idx_q == IDX_W'(k)) begin
          wr_pulse_d[k] = 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) regs_d[k][8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
      end
    end

    if (b_hs) bvalid_d = 1'b0;
  end

  // Read path: data is taken from regs_q at the AR handshake edge. A write that
  // commits on that same edge is therefore not yet visible to the read.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (r_hs) rvalid_d = 1'b0;

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = ar_in_range ? RESP_OKAY : RESP_OOR;
      rdata_d  = '0;
      for (int k = 0; k < C_NUM_REGS; k++) begin
        if (ar_idx == IDX_W'(k)) rdata_d = regs_q[k];
      end
    end
  end

  // NOTE: the register array is reset along with the control flops. reg_q is
  // visible at the ports and must read 0 while ARESETN is low, so the array
  // cannot be left as uninitialised RAM.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      for (int k = 0; k < C_NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its _d signal, with no dependence on statement order.
      ready_en_q <= ready_en_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      regs_q     <= regs_d;
    end
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign wr_pulse     = wr_pulse_q;

  for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_flat
    assign reg_q[k*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[k];
  end

endmodule

// File: tb/tb_justtest_regbank.sv
// -----------------------------------------------------------------------------
// tb_justtest_regbank
//
// Directed bench for justtest_regbank with the default build: 32-bit data,
// 8 registers and an 8-bit address. A table of write/read-back vectors
// covers strobes, ignored low address bits, the last register and an
// out-of-range index. Hand-written sequences cover W arriving before AW,
// back-pressure on B, a write and a read on the same edge, and reset
// mid-transaction.
// -----------------------------------------------------------------------------
module tb_justtest_regbank;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 8;

`ifdef JUSTTEST_REGBANK_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [AW-1:0] awaddr = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [AW-1:0] araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [NR*DW-1:0] reg_q;
  logic [NR-1:0]    wr_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt [NR];

  justtest_regbank #(.C_DATA_WIDTH(DW), .C_NUM_REGS(NR), .C_ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  // Count wr_pulse strobes at the falling edge. A pulse that lasts two
  // cycles is counted twice.
  initial for (int k = 0; k < NR; k++) pulse_cnt[k] = 0;
  always @(negedge ACLK) begin
    if (ARESETN) begin
      for (int k = 0; k < NR; k++) if (wr_pulse[k] === 1'b1) pulse_cnt[k]++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    while (bvalid !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    if (bvalid !== 1'b1) begin
      timeout_fail("b_wait");
      resp = 2'b11;
    end else begin
      resp = bresp;
      @(negedge ACLK);
    end
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    logic aw_hs, w_hs;
    int n = 0;
    @(negedge ACLK);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    while ((awvalid || wvalid) && n < 50) begin
      aw_hs = awvalid && (awready === 1'b1);
      w_hs  = wvalid && (wready === 1'b1);
      @(negedge ACLK);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    if (awvalid || wvalid) begin
      timeout_fail("aw_w_accept");
      awvalid = 1'b0; wvalid = 1'b0;
    end
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    int n = 0;
    @(negedge ACLK);
    araddr = addr; arvalid = 1'b1;
    while (arvalid && n < 50) begin
      if (arready === 1'b1) begin @(negedge ACLK); arvalid = 1'b0; end
      else @(negedge ACLK);
      n++;
    end
    if (arvalid) begin timeout_fail("ar_accept"); arvalid = 1'b0; end
    n = 0;
    rready = 1'b1;
    while (rvalid !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    if (rvalid !== 1'b1) begin
      timeout_fail("r_wait");
      data = '1; resp = 2'b11;
    end else begin
      data = rdata; resp = rresp;
      @(negedge ACLK);
    end
    rready = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
    logic [1:0]    exp_bresp;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_rresp;
  } vec_t;

  vec_t vecs [10];
  int   exp_pulse [NR];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]    resp, rr;
    logic [DW-1:0] rd;
    int            snap, bv_seen;

    vecs[0] = '{8'h00, 32'h0000_0001, 4'hF, 2'b00, 32'h0000_0001, 2'b00};
    vecs[1] = '{8'h04, 32'h0000_0002, 4'hF, 2'b00, 32'h0000_0002, 2'b00};
    vecs[2] = '{8'h08, 32'h0000_0003, 4'hF, 2'b00, 32'h0000_0003, 2'b00};
    vecs[3] = '{8'h0C, 32'h0000_0004, 4'hF, 2'b00, 32'h0000_0004, 2'b00};
    vecs[4] = '{8'h10, 32'hAABB_CCDD, 4'hF, 2'b00, 32'hAABB_CCDD, 2'b00};
    vecs[5] = '{8'h10, 32'h1122_3344, 4'h5, 2'b00, 32'hAA22_CC44, 2'b00};
    vecs[6] = '{8'h13, 32'h0000_0000, 4'h0, 2'b00, 32'hAA22_CC44, 2'b00};
    vecs[7] = '{8'h14, 32'hDEAD_BEEF, 4'h8, 2'b00, 32'hDE00_0000, 2'b00};
    vecs[8] = '{8'h1C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'hFFFF_FFFF, 2'b00};
    vecs[9] = '{8'h40, 32'h1234_5678, 4'hF, OOR,   32'h0000_0000, OOR  };
    exp_pulse = '{1, 1, 1, 1, 3, 1, 0, 1};

    // Outputs while reset is held
    #2;
    check("rst_reg_q_zero", 64'(reg_q != '0), 64'd0);
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_resp_data", {bresp, rresp, rdata}, 36'd0);
    check("rst_wr_pulse", wr_pulse, 8'h00);
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    check("ready_before_first_edge", {awready, wready, arready}, 3'b000);
    @(negedge ACLK);
    check("ready_after_first_edge", {awready, wready, arready}, 3'b111);

    // Table of write / read-back vectors
    foreach (vecs[i]) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
      check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_bresp);
      axi_read(vecs[i].addr, rd, rr);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_rresp", i), rr, vecs[i].exp_rresp);
    end
    for (int k = 0; k < NR; k++)
      check($sformatf("pulse_cnt_reg%0d", k), pulse_cnt[k], exp_pulse[k]);
    check("reg_q_reg4", reg_q[4*DW +: DW], 32'hAA22_CCD4 ^ 32'h0000_0090);
    check("reg_q_reg6", reg_q[6*DW +: DW], 32'h0);

    // W three cycles ahead of AW, bready low until the response appears
    @(negedge ACLK);
    wdata = 32'h66; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(negedge ACLK);
    wvalid = 1'b0;
    check("wfirst_wready_held", wready, 1'b0);
    repeat (2) @(negedge ACLK);
    check("wfirst_idle_state", {wready, awready, bvalid}, 3'b010);
    awaddr = 8'h18; awvalid = 1'b1;
    @(negedge ACLK);
    awvalid = 1'b0;
    check("wfirst_both_held", {awready, wready, bvalid}, 3'b000);
    @(negedge ACLK);
    check("wfirst_commit", {bvalid, wr_pulse[6]}, 2'b11);
    @(negedge ACLK);
    check("wfirst_pulse_drop_b_hold", {bvalid, wr_pulse[6], awready, wready}, 4'b1000);
    bready = 1'b1;
    @(negedge ACLK);
    bready = 1'b0;
    check("wfirst_after_b", {bvalid, awready, wready}, 3'b011);
    check("wfirst_pulses", pulse_cnt[6], 1);
    check("wfirst_reg6", reg_q[6*DW +: DW], 32'h66);

    // AW and W in the same cycle, B back-pressured for five cycles
    @(negedge ACLK);
    awaddr = 8'h18; awvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge ACLK);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_c%0d", i), {bvalid, awready, wready}, 3'b100);
      @(negedge ACLK);
    end
    bready = 1'b1;
    @(negedge ACLK);
    bready = 1'b0;
    check("bp_after_b", {bvalid, awready, wready}, 3'b011);
    check("bp_pulses", pulse_cnt[6], 2);
    check("bp_reg6", reg_q[6*DW +: DW], 32'h77);

    // Write commit and AR handshake on the same edge, register 2
    axi_write(8'h08, 32'h9, 4'hF, resp);
    check("same_edge_setup_bresp", resp, 2'b00);
    @(negedge ACLK);
    awaddr = 8'h08; awvalid = 1'b1; wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(negedge ACLK);
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 8'h08; arvalid = 1'b1;
    @(negedge ACLK);
    arvalid = 1'b0;
    check("same_edge_commit", {bvalid, wr_pulse[2], rvalid}, 3'b111);
    check("same_edge_old_data", rdata, 32'h9);
    rready = 1'b1;
    @(negedge ACLK);
    rready = 1'b0; bready = 1'b0;
    check("same_edge_done", {rvalid, bvalid}, 2'b00);
    axi_read(8'h08, rd, rr);
    check("same_edge_new_data", rd, 32'h5);

    // Reset after AW is accepted but before W arrives
    snap = pulse_cnt[0];
    @(negedge ACLK);
    awaddr = 8'h00; awvalid = 1'b1;
    @(negedge ACLK);
    awvalid = 1'b0;
    check("abort_aw_held", awready, 1'b0);
    ARESETN = 1'b0;
    #1;
    check("abort_rst_reg_q", 64'(reg_q != '0), 64'd0);
    check("abort_rst_outputs", {awready, wready, arready, bvalid, rvalid, wr_pulse}, 13'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    for (int k = 0; k < NR; k++) begin
      axi_read(AW'(4*k), rd, rr);
      check($sformatf("abort_read_reg%0d", k), rd, 32'h0);
    end
    // W alone must not pair with the discarded AW
    wdata = 32'hBAD; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(negedge ACLK);
    wvalid = 1'b0;
    bv_seen = 0;
    repeat (10) begin
      if (bvalid === 1'b1) bv_seen++;
      @(negedge ACLK);
    end
    check("abort_no_bvalid", bv_seen, 0);
    check("abort_no_pulse", pulse_cnt[0], snap);
    // A fresh AW now completes the held W
    awaddr = 8'h00; awvalid = 1'b1;
    @(negedge ACLK);
    awvalid = 1'b0;
    wait_b(resp);
    check("abort_follow_bresp", resp, 2'b00);
    check("abort_follow_pulse", pulse_cnt[0], snap + 1);
    axi_read(8'h00, rd, rr);
    check("abort_follow_rdata", rd, 32'hBAD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
